// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction prefetch stage.
//   - fetch_state_e : controller states
//   - default width constants for parameter defaults
//   - fetch_entry_t : prefetch queue entry {pc, insn} at the default widths
package fetch_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 32;
  localparam int DEPTH_DEF     = 4;
  localparam int ADDR_STEP_DEF = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEMAND_WAIT = 2'd1,
    PF_WAIT     = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_queue.sv
// prefetch_queue: synchronous FIFO of DEPTH entries with single-cycle flush.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write an entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   flush             empty the queue in one cycle (wins over push/pop)
//   head              peek at the oldest entry
//   count             occupancy 0..DEPTH
//   full, empty       occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module prefetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wp, rp;
  logic                    do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp];

  // Storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_prefetch.sv
// instruction_prefetch: fetch stage with a sequential prefetch queue.
// Accepts a PC over DIR/ack_prev, returns {insn, pc} over DOR/ack_from_next.
// While idle it reads PC+ADDR_STEP onward into a DEPTH-entry queue; a request
// matching the queue head is served in one cycle, anything else flushes the
// queue and goes to memory.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   DIR, data_in, ack_prev     request handshake from previous stage
//   DOR, data_out, pc_out      result to next stage, held until ack_from_next
//   ack_from_next              next stage consumed the result
//   mem_en, mem_addr, mem_di   read port to memory (mem_di tied to 0)
//   mem_do, mem_do_ack         read data and one-cycle completion
// Optional build macro FETCH_STATS_EN adds hit_count/miss_count (16-bit,
// saturating) outputs.
module instruction_prefetch
  import fetch_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_STEP = ADDR_STEP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DIR,
  input  logic [ADDR_W-1:0] data_in,
  output logic              ack_prev,
  output logic              DOR,
  input  logic              ack_from_next,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do,
  input  logic              mem_do_ack
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] insn;
  } entry_t;

  fetch_state_e      state;
  logic [ADDR_W-1:0] demand_pc;
  logic [ADDR_W-1:0] pf_pc;
  logic              pf_valid;

  entry_t            q_head, q_push_data;
  logic              q_push, q_pop, q_flush, q_full, q_empty;
  logic [CW-1:0]     q_count;
  logic              accept, hit, pf_start;

  assign mem_di = '0;

  // A request is taken only in IDLE, with the output slot free and not in the
  // cycle right after a previous accept (DIR is still stale then).
  assign accept   = (state == IDLE) && DIR && !DOR && !ack_prev;
  assign hit      = accept && !q_empty && (q_head.pc == data_in);
  assign pf_start = (state == IDLE) && !accept && pf_valid && (q_count < CW'(DEPTH));

  assign q_pop       = hit;
  assign q_flush     = accept && !hit;
  assign q_push      = (state == PF_WAIT) && mem_do_ack && !q_full;
  assign q_push_data = '{pc: pf_pc, insn: mem_do};

  prefetch_queue #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (q_flush),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      DOR       <= 1'b0;
      ack_prev  <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      data_out  <= '0;
      pc_out    <= '0;
      demand_pc <= '0;
      pf_pc     <= '0;
      pf_valid  <= 1'b0;
    end else begin
      ack_prev <= 1'b0;
      if (DOR && ack_from_next) DOR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            ack_prev <= 1'b1;
            if (hit) begin
              data_out <= q_head.insn;
              pc_out   <= data_in;
              DOR      <= 1'b1;
            end else begin
              demand_pc <= data_in;
              pf_pc     <= data_in + ADDR_W'(ADDR_STEP);
              pf_valid  <= 1'b1;
              mem_en    <= 1'b1;
              mem_addr  <= data_in;
              state     <= DEMAND_WAIT;
            end
          end else if (pf_start) begin
            mem_en   <= 1'b1;
            mem_addr <= pf_pc;
            state    <= PF_WAIT;
          end
        end
        DEMAND_WAIT: begin
          if (mem_do_ack) begin
            data_out <= mem_do;
            pc_out   <= demand_pc;
            DOR      <= 1'b1;
            mem_en   <= 1'b0;
            state    <= IDLE;
          end
        end
        PF_WAIT: begin
          if (mem_do_ack) begin
            pf_pc  <= pf_pc + ADDR_W'(ADDR_STEP);
            mem_en <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != 16'hFFFF)         hit_count  <= hit_count + 16'd1;
      if (q_flush && miss_count != 16'hFFFF)    miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_prefetch.sv
module tb_instruction_prefetch;

  localparam int DEPTH   = 4;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        DIR = 1'b0;
  logic [31:0] data_in = '0;
  logic        ack_prev;
  logic        DOR;
  logic        ack_from_next = 1'b0;
  logic [31:0] data_out;
  logic [31:0] pc_out;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_do = '0;
  logic        mem_do_ack = 1'b0;
`ifdef FETCH_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  instruction_prefetch #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .ADDR_STEP(4)
  ) dut (
    .clk(clk), .reset(reset), .DIR(DIR), .data_in(data_in),
    .ack_prev(ack_prev), .DOR(DOR), .ack_from_next(ack_from_next),
    .data_out(data_out), .pc_out(pc_out), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do),
    .mem_do_ack(mem_do_ack)
`ifdef FETCH_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;
  bit mem_auto = 1;
  int wait_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory: answers each read MEM_LAT cycles after mem_en rises.
  always @(negedge clk) begin
    if (mem_auto) begin
      mem_do_ack = 1'b0;
      if (mem_en === 1'b1 && !reset) begin
        if (wait_cnt == MEM_LAT - 1) begin
          mem_do_ack = 1'b1;
          mem_do     = mem_word(mem_addr);
          wait_cnt   = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end else wait_cnt = 0;
  end

  // Log of every new memory read address.
  logic [31:0] addr_log[$];
  bit men_q = 0;
  always @(negedge clk) begin
    if (mem_en === 1'b1 && !men_q) addr_log.push_back(mem_addr);
    men_q = (mem_en === 1'b1);
  end

  // Reference model: a queue of fetched {pc, insn}, one outstanding read,
  // one output slot.
  typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;
  ent_t        mq[$];
  bit          m_dor, m_ackp, m_men, m_pf_on, m_dem;
  logic [31:0] m_addr, m_pc, m_dout, m_pf_pc;

  always @(posedge clk) begin
    if (reset) begin
      m_dor = 0; m_ackp = 0; m_men = 0; m_pf_on = 0; m_dem = 0;
      m_addr = '0; m_pc = '0; m_dout = '0; m_pf_pc = '0;
      mq.delete();
    end else begin
      bit ackp_n, dor_n;
      ackp_n = 0;
      dor_n  = m_dor && !ack_from_next;
      if (m_men) begin
        if (mem_do_ack) begin
          m_men = 0;
          if (m_dem) begin
            dor_n = 1; m_dout = mem_do; m_pc = m_addr;
          end else begin
            mq.push_back('{m_addr, mem_do});
            m_pf_pc = m_addr + 32'd4;
          end
        end
      end else if (DIR && !m_dor && !m_ackp) begin
        ackp_n = 1;
        if (mq.size() > 0 && mq[0].pc == data_in) begin
          dor_n = 1; m_dout = mq[0].insn; m_pc = data_in;
          mq.delete(0);
        end else begin
          mq.delete();
          m_pf_on = 1; m_pf_pc = data_in + 32'd4;
          m_men = 1; m_dem = 1; m_addr = data_in;
        end
      end else if (m_pf_on && mq.size() < DEPTH) begin
        m_men = 1; m_dem = 0; m_addr = m_pf_pc;
      end
      m_dor  = dor_n;
      m_ackp = ackp_n;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_dor", DOR, m_dor);
      chk("model_ack_prev", ack_prev, m_ackp);
      chk("model_mem_en", mem_en, m_men);
      if (m_men) chk("model_mem_addr", mem_addr, m_addr);
      if (m_dor) begin
        chk("model_data_out", data_out, m_dout);
        chk("model_pc_out", pc_out, m_pc);
      end
      chk("mem_di_zero", mem_di, 0);
    end
  end

  task automatic request(input logic [31:0] pc);
    bit got;
    got = 0;
    DIR = 1'b1;
    data_in = pc;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ack_prev === 1'b1) got = 1;
    end
    DIR = 1'b0;
    if (!got) timeout_fail("request_ack");
  endtask

  task automatic wait_dor(output int n);
    n = 0;
    while (DOR !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (DOR !== 1'b1) timeout_fail("wait_dor");
  endtask

  task automatic consume();
    int n;
    wait_dor(n);
    ack_from_next = 1'b1;
    @(negedge clk);
    ack_from_next = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    idle(3);
    reset = 1'b0;
    chk("rst_dor", DOR, 0);
    chk("rst_ack_prev", ack_prev, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_pc_out", pc_out, 0);
    cmp_on = 1;

    // Cold miss at 0x100
    addr_log.delete();
    request(32'h100);
    chk("miss_ack_prev", ack_prev, 1);
    chk("miss_mem_en", mem_en, 1);
    chk("miss_mem_addr", mem_addr, 32'h100);
    wait_dor(n);
    chk("miss_latency", n, 2);
    chk("miss_data", data_out, 32'hDEADBEEF);
    chk("miss_pc", pc_out, 32'h100);
    consume();

    // Prefetch fills the queue, then stalls
    idle(25);
    chk("pf_count", addr_log.size(), 5);
    if (addr_log.size() == 5) begin
      chk("pf_addr0", addr_log[1], 32'h104);
      chk("pf_addr1", addr_log[2], 32'h108);
      chk("pf_addr2", addr_log[3], 32'h10C);
      chk("pf_addr3", addr_log[4], 32'h110);
    end
    chk("pf_stall", mem_en, 0);

    // Hit at 0x104, then refill at 0x114
    addr_log.delete();
    request(32'h104);
    chk("hit_dor", DOR, 1);
    chk("hit_pc", pc_out, 32'h104);
    chk("hit_data", data_out, mem_word(32'h104));
    chk("hit_no_mem", mem_en, 0);
    consume();
    idle(10);
    chk("refill_count", addr_log.size(), 1);
    if (addr_log.size() == 1) chk("refill_addr", addr_log[0], 32'h114);

    // Branch miss to 0x200
    addr_log.delete();
    request(32'h200);
    chk("br_mem_en", mem_en, 1);
    chk("br_mem_addr", mem_addr, 32'h200);
    wait_dor(n);
    chk("br_pc", pc_out, 32'h200);
    chk("br_data", data_out, mem_word(32'h200));

    // Output backpressure with a request waiting
    DIR = 1'b1;
    data_in = 32'h204;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_dor", DOR, 1);
      chk("hold_no_ack", ack_prev, 0);
      chk("hold_data", data_out, mem_word(32'h200));
    end
    ack_from_next = 1'b1;
    @(negedge clk);
    ack_from_next = 1'b0;
    chk("release_dor", DOR, 0);
    chk("release_no_ack", ack_prev, 0);
    request(32'h204);
    chk("held_hit_dor", DOR, 1);
    chk("held_hit_pc", pc_out, 32'h204);
    if (addr_log.size() >= 2) chk("br_pf_resume", addr_log[1], 32'h204);
    else timeout_fail("br_pf_resume");
    consume();

    // Address wrap
    idle(12);
    addr_log.delete();
    request(32'hFFFF_FFFC);
    wait_dor(n);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    consume();
    idle(8);
    if (addr_log.size() >= 2) chk("wrap_pf_addr", addr_log[1], 32'h0);
    else timeout_fail("wrap_pf_addr");
    request(32'h0);
    chk("wrap_hit_dor", DOR, 1);
    chk("wrap_hit_pc", pc_out, 32'h0);
    chk("wrap_hit_data", data_out, mem_word(32'h0));
    consume();

    // Reset during a prefetch, then a stray completion
    mem_auto = 0;
    mem_do_ack = 1'b0;
    n = 0;
    while (mem_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (mem_en !== 1'b1) timeout_fail("pf_wait_enter");
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_en", mem_en, 0);
    chk("rst_mid_dor", DOR, 0);
    reset = 1'b0;
    mem_do_ack = 1'b1;
    mem_do = 32'h1234_5678;
    @(negedge clk);
    mem_do_ack = 1'b0;
    chk("late_ack_dor", DOR, 0);
    chk("late_ack_mem_en", mem_en, 0);
    @(negedge clk);
    chk("late_ack_idle", mem_en, 0);
    mem_auto = 1;
    request(32'h4);
    chk("post_rst_miss_en", mem_en, 1);
    chk("post_rst_miss_addr", mem_addr, 32'h4);
    wait_dor(n);
    chk("post_rst_pc", pc_out, 32'h4);
    consume();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_prefetch.md
Name: instruction_prefetch

Overview:
Parametrised successor to the single-shot fetch stage. It accepts a PC from the previous stage over the DIR/ack_prev handshake and delivers {instruction, PC} to the next stage over DOR/ack_from_next. Between requests it sequentially prefetches PC+ADDR_STEP onward into a DEPTH-entry queue, so straight-line code is served without a memory access. A non-matching PC (branch) flushes the queue and refetches.

Parameters:
DATA_W, 32, instruction word width
ADDR_W, 32, PC / memory address width
DEPTH, 4, prefetch queue entries; power of 2, >=2
ADDR_STEP, 4, PC increment between sequential instructions

Ports:
clk  in  1  clock; single clock domain
reset  in  1  synchronous, active-high reset
DIR  in  1  previous stage presents a PC request
data_in  in  ADDR_W  requested PC
ack_prev  out  1  one-cycle pulse: request accepted
DOR  out  1  data_out/pc_out valid
ack_from_next  in  1  next stage consumed output
data_out  out  DATA_W  fetched instruction
pc_out  out  ADDR_W  PC of data_out
mem_en  out  1  memory read request, held until mem_do_ack
mem_addr  out  ADDR_W  read address
mem_di  out  DATA_W  tied to 0 (read-only port)
mem_do  in  DATA_W  read data, valid with mem_do_ack
mem_do_ack  in  1  one-cycle read completion

Behaviour:
- Reset: state=IDLE, DOR=0, ack_prev=0, mem_en=0, mem_addr=0, data_out=0, pc_out=0, queue count=0, pf_valid=0. Reset mid-fetch drops mem_en next cycle; a late mem_do_ack arriving in IDLE is ignored.
- Queue entry = {pc, insn}. Head is peekable. Flush sets count to 0 in one cycle.
- States: IDLE, DEMAND_WAIT, PF_WAIT. At most one memory access is outstanding. A memory access is outstanding only in a WAIT state. mem_en and mem_addr are constant for the whole WAIT state.
- IDLE, request accept: DIR=1, DOR=0, ack_prev=0. Request takes priority over prefetch.
  - Hit (count>0 and head.pc==data_in): pop the head; data_out<=head.insn; pc_out<=data_in; DOR<=1; ack_prev<=1; stay in IDLE. No memory access. Latency is 1 cycle.
  - Miss: ack_prev<=1; flush the queue; demand_pc<=data_in; pf_pc<=data_in+ADDR_STEP; pf_valid<=1; mem_en<=1; mem_addr<=data_in; go to DEMAND_WAIT.
- IDLE, prefetch: if no request is accepted, pf_valid=1 and count<DEPTH, then mem_en<=1, mem_addr<=pf_pc, go to PF_WAIT.
- DEMAND_WAIT: on mem_do_ack, data_out<=mem_do, pc_out<=demand_pc, DOR<=1, mem_en<=0, go to IDLE. Latency from accept = memory latency + 1.
- PF_WAIT: on mem_do_ack, push {pf_pc, mem_do}, pf_pc<=pf_pc+ADDR_STEP, mem_en<=0, go to IDLE. DIR is not sampled in a WAIT state; the request simply waits.
- ack_prev is high for exactly one cycle. DIR is ignored in the cycle ack_prev=1. The previous stage drops or changes DIR after seeing ack_prev.
- DOR stays 1 and data_out/pc_out stay stable until ack_from_next; DOR clears the next cycle. ack_from_next with DOR=0 is ignored. Prefetch continues while DOR=1.
- Arithmetic: pf_pc wraps modulo 2^ADDR_W (0xFFFFFFFC+4 -> 0x0). Full queue: prefetch stalls, mem_en stays 0. Empty queue: every request is a miss.

Optional Feature:
FETCH_STATS_EN: when defined, adds outputs hit_count[15:0] and miss_count[15:0]. Each counter increments on an accepted hit or miss, saturates at 0xFFFF and clears on reset. When not defined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg: state encodings (IDLE/DEMAND_WAIT/PF_WAIT), default width constants, queue-entry struct {pc, insn}.
- Sub-module prefetch_queue: synchronous FIFO of DEPTH entries. Provides push, pop, flush, head peek, count, full and empty. Pointer wrap uses log2(DEPTH) bits; count is 0..DEPTH.

Test Plan:
- Reset, then DIR with data_in=0x100; memory acks 0xDEADBEEF after 2 cycles -> ack_prev pulse, mem_en with addr 0x100, then DOR=1, data_out=0xDEADBEEF, pc_out=0x100.
- Continue with DEPTH=4, no requests -> prefetch reads 0x104, 0x108, 0x10C, 0x110, then mem_en stays 0. Request 0x104 -> DOR the next cycle with no memory access; refill read 0x114 issued.
- Queue holds 0x108..0x114; request 0x200 -> miss, flush, read 0x200, DOR with pc_out=0x200, prefetch resumes at 0x204.
- Hold ack_from_next=0 for 10 cycles while DIR=1 -> DOR stays 1, data_out stable, no ack_prev; then ack -> DOR=0 the next cycle and the request is accepted.
- Request 0xFFFFFFFC -> next prefetch address 0x00000000, pc_out of the subsequent hit is 0x0.
- Assert reset during PF_WAIT -> mem_en=0 the next cycle, count=0, mem_do_ack in the following cycle ignored (no push, DOR stays 0).
